// File: rtl/elastic_eager_fork.sv
// rtl/elastic_eager_fork.sv - eager valid/stop fork of one producer to FORK_NUM consumers
// Optional one-entry input register selected by ELASTIC_EAGER_FORK_INPUT_REG_EN.
module elastic_eager_fork #(
    parameter int DATA_WIDTH = 32,
    parameter int FORK_NUM   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_input,
    output logic                           stop_input,
    input  logic [DATA_WIDTH-1:0]          data_input,
    output logic [FORK_NUM-1:0]            valid_output,
    input  logic [FORK_NUM-1:0]            stop_output,
    output logic [FORK_NUM*DATA_WIDTH-1:0] data_output,
    output logic [FORK_NUM-1:0]            DEBUG_done
);

    logic                  cv;
    logic [DATA_WIDTH-1:0] cd;
    logic [FORK_NUM-1:0]   done;
    logic [FORK_NUM-1:0]   take;
    logic                  all_taken;

`ifdef ELASTIC_EAGER_FORK_INPUT_REG_EN
    logic                  full;
    logic [DATA_WIDTH-1:0] hold;

    assign cv = full;
    assign cd = hold;

    // Registered stall: refill is allowed in the same cycle the held token retires.
    assign stop_input = full && !all_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (valid_input && !stop_input) begin
            full <= 1'b1;
        end else if (all_taken) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_input && !stop_input) begin
            hold <= data_input;
        end
    end
`else
    assign cv         = valid_input;
    assign cd         = data_input;
    assign stop_input = valid_input && !all_taken;
`endif

    // Branches that already took the token drop valid until it retires.
    assign valid_output = {FORK_NUM{cv}} & ~done;
    assign take         = valid_output & ~stop_output;
    assign all_taken    = &(done | take);
    assign data_output  = {FORK_NUM{cd}};
    assign DEBUG_done   = done;

    always_ff @(posedge clk) begin
        if (reset) begin
            done <= '0;
        end else if (cv && all_taken) begin
            done <= '0;
        end else begin
            done <= done | take;
        end
    end

endmodule

// File: tb/tb_elastic_eager_fork.sv
// tb/tb_elastic_eager_fork.sv - self-checking bench for elastic_eager_fork
module tb_elastic_eager_fork;

    localparam int W = 32;
    localparam int F = 2;
`ifdef ELASTIC_EAGER_FORK_INPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           valid_input = 1'b0;
    logic           stop_input;
    logic [W-1:0]   data_input = '0;
    logic [F-1:0]   valid_output;
    logic [F-1:0]   stop_output = '0;
    logic [F*W-1:0] data_output;
    logic [F-1:0]   DEBUG_done;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] rxq [F][$];

    elastic_eager_fork #(.DATA_WIDTH(W), .FORK_NUM(F)) dut (
        .clk(clk),
        .reset(reset),
        .valid_input(valid_input),
        .stop_input(stop_input),
        .data_input(data_input),
        .valid_output(valid_output),
        .stop_output(stop_output),
        .data_output(data_output),
        .DEBUG_done(DEBUG_done)
    );

    always #5 clk = ~clk;

    // Producer must hold its token while stalled.
    logic         stall_q = 1'b0;
    logic [W-1:0] data_q = '0;
    always @(posedge clk) begin
        if (!reset && stall_q)
            assert (valid_input && data_input == data_q)
                else $error("producer hold violation");
        stall_q <= valid_input && stop_input && !reset;
        data_q  <= data_input;
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [F-1:0] s);
        valid_input = v;
        data_input  = d;
        stop_output = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        @(negedge clk);
        for (int i = 0; i < F; i++)
            if (valid_output[i] && !stop_output[i])
                rxq[i].push_back(data_output[i*W +: W]);
    endtask

    task automatic clear_rx();
        for (int i = 0; i < F; i++) rxq[i].delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0);
        next_cycle();
        next_cycle();
        observe();
        checks++;
        if (DEBUG_done !== 2'b00 || valid_output !== 2'b00 || stop_input !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got done=%b vo=%b si=%b exp 00 00 0", DEBUG_done, valid_output, stop_input);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single();
        clear_rx();
        drive(1'b1, 32'h0000_00A5, 2'b00);
        observe();
`ifdef ELASTIC_EAGER_FORK_INPUT_REG_EN
        checks++;
        if (valid_output !== 2'b00 || stop_input !== 1'b0) begin
            failures++;
            $display("FAIL single_load got vo=%b si=%b exp 00 0", valid_output, stop_input);
        end
        next_cycle();
        drive(1'b0, '0, 2'b00);
        observe();
`endif
        checks++;
        if (valid_output !== 2'b11 || stop_input !== 1'b0) begin
            failures++;
            $display("FAIL single_valid got vo=%b si=%b exp 11 0", valid_output, stop_input);
        end
        for (int i = 0; i < F; i++) begin
            checks++;
            if (data_output[i*W +: W] !== 32'h0000_00A5) begin
                failures++;
                $display("FAIL single_lane%0d got=%h exp=000000a5", i, data_output[i*W +: W]);
            end
        end
        next_cycle();
        drive(1'b0, '0, 2'b00);
        observe();
        checks++;
        if (DEBUG_done !== 2'b00 || valid_output !== 2'b00 || rxq[0].size() != 1 || rxq[1].size() != 1) begin
            failures++;
            $display("FAIL single_retire got done=%b vo=%b n0=%0d n1=%0d exp 00 00 1 1",
                     DEBUG_done, valid_output, rxq[0].size(), rxq[1].size());
        end
        next_cycle();
    endtask

    task automatic test_partial();
        clear_rx();
        drive(1'b1, 32'h11, 2'b10);
        observe();
        checks++;
        if (valid_output !== 2'b11 || stop_input !== 1'b1) begin
            failures++;
            $display("FAIL partial_c0 got vo=%b si=%b exp 11 1", valid_output, stop_input);
        end
        next_cycle();
        drive(1'b1, 32'h11, 2'b00);
        observe();
        checks++;
        if (DEBUG_done !== 2'b01 || valid_output !== 2'b10 || stop_input !== 1'b0) begin
            failures++;
            $display("FAIL partial_c1 got done=%b vo=%b si=%b exp 01 10 0", DEBUG_done, valid_output, stop_input);
        end
        next_cycle();
        drive(1'b0, '0, 2'b00);
        observe();
        checks++;
        if (DEBUG_done !== 2'b00 || rxq[0].size() != 1 || rxq[1].size() != 1 ||
            rxq[0][0] !== 32'h11 || rxq[1][0] !== 32'h11) begin
            failures++;
            $display("FAIL partial_retire got done=%b n0=%0d n1=%0d exp 00 1 1",
                     DEBUG_done, rxq[0].size(), rxq[1].size());
        end
        next_cycle();
    endtask

    task automatic test_stall();
        int bad;
        clear_rx();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h77, 2'b11);
            observe();
            if (valid_output !== 2'b11 || stop_input !== 1'b1) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got bad_cycles=%0d exp 0", bad);
        end
        drive(1'b1, 32'h77, 2'b00);
        observe();
        checks++;
        if (stop_input !== 1'b0 || valid_output !== 2'b11) begin
            failures++;
            $display("FAIL stall_release got si=%b vo=%b exp 0 11", stop_input, valid_output);
        end
        next_cycle();
        drive(1'b0, '0, 2'b00);
        observe();
        checks++;
        if (rxq[0].size() != 1 || rxq[1].size() != 1 || DEBUG_done !== 2'b00) begin
            failures++;
            $display("FAIL stall_count got n0=%0d n1=%0d done=%b exp 1 1 00", rxq[0].size(), rxq[1].size(), DEBUG_done);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        clear_rx();
        drive(1'b1, 32'h33, 2'b10);
        observe();
        next_cycle();
        checks++;
        if (DEBUG_done !== 2'b01) begin
            failures++;
            $display("FAIL rmid_partial got done=%b exp 01", DEBUG_done);
        end
        reset = 1'b1;
        drive(1'b0, '0, 2'b00);
        next_cycle();
        reset = 1'b0;
        observe();
        checks++;
        if (DEBUG_done !== 2'b00 || valid_output !== 2'b00) begin
            failures++;
            $display("FAIL rmid_cleared got done=%b vo=%b exp 00 00", DEBUG_done, valid_output);
        end
        next_cycle();
        clear_rx();
        drive(1'b1, 32'h33, 2'b00);
        observe();
        checks++;
        if (valid_output !== 2'b11 || stop_input !== (LAT == 0 ? 1'b0 : 1'b0)) begin
            if (LAT == 0 || valid_output !== 2'b00) begin
                failures++;
                $display("FAIL rmid_reoffer got vo=%b si=%b exp 11 0", valid_output, stop_input);
            end
        end
        next_cycle();
        drive(1'b0, '0, 2'b00);
        observe();
        next_cycle();
        checks++;
        if (rxq[0].size() != 1 || rxq[1].size() != 1 || rxq[0][0] !== 32'h33 || rxq[1][0] !== 32'h33) begin
            failures++;
            $display("FAIL rmid_delivery got n0=%0d n1=%0d exp 1 1 of 33", rxq[0].size(), rxq[1].size());
        end
    endtask

    task automatic test_stream_random();
        int k;
        int cyc;
        logic stalled;
        logic v;
        clear_rx();
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        while (!(k == 16 && rxq[0].size() >= 16 && rxq[1].size() >= 16) && cyc < 2000) begin
            v = (k < 16) && (stalled || $urandom_range(0, 3) != 0);
            drive(v, W'(k), F'($urandom));
            observe();
            stalled = v && stop_input;
            if (v && !stop_input) k++;
            cyc++;
            next_cycle();
        end
        drive(1'b0, '0, 2'b00);
        for (int c = 0; c < 4; c++) begin
            observe();
            next_cycle();
        end
        checks++;
        if (cyc >= 2000) begin
            failures++;
            $display("FAIL stream_timeout got cycles=%0d exp <2000", cyc);
        end
        for (int i = 0; i < F; i++) begin
            checks++;
            if (rxq[i].size() != 16) begin
                failures++;
                $display("FAIL stream_count%0d got=%0d exp=16", i, rxq[i].size());
            end
            for (int j = 0; j < rxq[i].size(); j++) begin
                checks++;
                if (rxq[i][j] !== W'(j)) begin
                    failures++;
                    $display("FAIL stream_order%0d idx=%0d got=%0d exp=%0d", i, j, rxq[i][j], j);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int cyc;
        clear_rx();
        k = 0;
        cyc = 0;
        while (!(rxq[0].size() >= 16 && rxq[1].size() >= 16) && cyc < 100) begin
            drive(k < 16, W'(k), 2'b00);
            observe();
            if (valid_input && !stop_input) k++;
            cyc++;
            next_cycle();
        end
        drive(1'b0, '0, 2'b00);
        checks++;
        if (cyc != 16 + LAT) begin
            failures++;
            $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, 16 + LAT);
        end
        for (int i = 0; i < F; i++) begin
            checks++;
            if (rxq[i].size() != 16 || rxq[i][0] !== 0 || rxq[i][15] !== 15) begin
                failures++;
                $display("FAIL b2b_order%0d got n=%0d exp 16 tokens 0..15", i, rxq[i].size());
            end
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
`ifndef ELASTIC_EAGER_FORK_INPUT_REG_EN
        test_partial();
        test_stall();
        test_reset_mid();
`endif
        test_stream_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
